// File: rtl/div_unit.sv
// Signed 32-bit sequential divider: one restoring shift-subtract step per clock,
// producing a truncated quotient (lo) and a dividend-signed remainder (hi).
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_on,
    input  logic [31:0] div_a,
    input  logic [31:0] div_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        signA_q, signA_d;
    logic        signB_q, signB_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        divZero_q, divZero_d;
    logic        done_q, done_d;

    logic [31:0] absA;
    logic [31:0] absB;
    logic [32:0] remShift;
    logic [31:0] remTrial;
    logic        quoBit;
    logic [31:0] remStep;
    logic [31:0] quoStep;

    // Operand magnitudes and a single restoring iteration; the quotient register
    // doubles as the dividend shifter, feeding its MSB into the partial remainder.
    always_comb begin
        absA     = div_a[31] ? (~div_a + 32'd1) : div_a;
        absB     = div_b[31] ? (~div_b + 32'd1) : div_b;
        remShift = {rem_q, quo_q[31]};
        quoBit   = (remShift >= {1'b0, dvsr_q});
        remTrial = remShift[31:0] - dvsr_q;
        remStep  = quoBit ? remTrial : remShift[31:0];
        quoStep  = {quo_q[30:0], quoBit};
    end

    // Next-state and datapath control; div_on only matters while idle.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        signA_d   = signA_q;
        signB_d   = signB_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divZero_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_on) begin
                    if (div_b == 32'd0) begin
                        divZero_d = 1'b1;
                    end else begin
                        signA_d = div_a[31];
                        signB_d = div_b[31];
                        quo_d   = absA;
                        dvsr_d  = absB;
                        rem_d   = 32'd0;
                        count_d = 6'd0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d   = remStep;
                quo_d   = quoStep;
                count_d = count_q + 6'd1;
                if (count_q == 6'd31) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    lo_d    = (signA_q ^ signB_q) ? (~quoStep + 32'd1) : quoStep;
                    hi_d    = signA_q ? (~remStep + 32'd1) : remStep;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 6'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            signA_q   <= 1'b0;
            signB_q   <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            divZero_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            signA_q   <= signA_d;
            signB_q   <= signB_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divZero_q <= divZero_d;
            done_q    <= done_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = divZero_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        div_on;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .div_on   (div_on),
        .div_a    (div_a),
        .div_b    (div_b),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present operands at a negedge, let the next posedge accept them, and
    // confirm the unit went busy. Optionally leaves div_on asserted.
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b, input bit holdOn);
        div_a  = a;
        div_b  = b;
        div_on = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_accept_busy"}, {31'd0, busy}, 32'd1);
        if (!holdOn) div_on = 1'b0;
    endtask

    // Wait (bounded) for done, checking latency, hold of old results during RUN,
    // the final result, busy length, and the return to idle.
    task automatic waitDone(input string tag, input logic [31:0] expLo, input logic [31:0] expHi);
        int          edges     = 0;
        int          busyCount = 1;
        bit          seen      = 0;
        logic [31:0] prevLo    = lo;
        logic [31:0] prevHi    = hi;
        while (!seen && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (busy) busyCount++;
            if (done) seen = 1;
            if (edges == 31) begin
                checkOutput({tag, "_lo_held"}, lo, prevLo);
                checkOutput({tag, "_hi_held"}, hi, prevHi);
            end
        end
        checkOutput({tag, "_latency"}, edges, 32);
        checkOutput({tag, "_lo"}, lo, expLo);
        checkOutput({tag, "_hi"}, hi, expHi);
        checkOutput({tag, "_divzero"}, {31'd0, div_zero}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_busy_cycles"}, busyCount, 33);
        checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_idle_divzero"}, {31'd0, div_zero}, 32'd0);
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expLo, input logic [31:0] expHi);
        applyStimulus(tag, a, b, 1'b0);
        waitDone(tag, expLo, expHi);
    endtask

    // Hard stop in case something upstream stalls forever.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneSeen;
        reset  = 1'b1;
        div_on = 1'b0;
        div_a  = 32'd0;
        div_b  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_divzero", {31'd0, div_zero}, 32'd0);

        // First edge after reset release accepts.
        reset = 1'b0;
        runOp("7div2", 32'd7, 32'd2, 32'h0000_0003, 32'h0000_0001);

        // Divide by zero: pulse, stay idle, results untouched; back-to-back zero
        // re-pulses; a nonzero divisor on the following edge is accepted.
        div_a  = 32'd20;
        div_b  = 32'd0;
        div_on = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("dz1_flag", {31'd0, div_zero}, 32'd1);
        checkOutput("dz1_busy", {31'd0, busy}, 32'd0);
        checkOutput("dz1_done", {31'd0, done}, 32'd0);
        checkOutput("dz1_lo", lo, 32'h0000_0003);
        checkOutput("dz1_hi", hi, 32'h0000_0001);
        @(posedge clk);
        @(negedge clk);
        checkOutput("dz2_flag", {31'd0, div_zero}, 32'd1);
        checkOutput("dz2_busy", {31'd0, busy}, 32'd0);
        div_b = 32'd5;
        @(posedge clk);
        @(negedge clk);
        checkOutput("dz3_flag", {31'd0, div_zero}, 32'd0);
        checkOutput("dz3_busy", {31'd0, busy}, 32'd1);
        div_on = 1'b0;
        waitDone("20div5", 32'd4, 32'd0);

        // Sign handling and boundaries.
        runOp("m7div2",  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
        runOp("7divm2",  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
        runOp("m7divm2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF);
        runOp("minDivm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
        runOp("minDiv1", 32'h8000_0000, 32'd1,        32'h8000_0000, 32'h0000_0000);
        runOp("6divm3",  32'd6,         32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0000);
        runOp("m6div4",  32'hFFFF_FFFA, 32'd4,        32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runOp("0div5",   32'd0,         32'd5,        32'd0,         32'd0);

        // div_on held high; operands change (including a zero divisor) mid-run.
        applyStimulus("hold", 32'd1000, 32'd7, 1'b1);
        div_a = 32'd5;
        div_b = 32'd0;
        waitDone("hold", 32'd142, 32'd6);
        div_a = 32'd9;
        div_b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        checkOutput("hold_reaccept_busy", {31'd0, busy}, 32'd1);
        div_on = 1'b0;
        waitDone("9div4", 32'd2, 32'd1);

        // Reset in the middle of RUN aborts cleanly.
        applyStimulus("abort", 32'd1000, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_divzero", {31'd0, div_zero}, 32'd0);
        reset    = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 32'd0);
        runOp("100div7", 32'd100, 32'd7, 32'd14, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
